// File: rtl/receiver_array_pkg.sv
// Shared widths, frame field offsets and helpers for the receiver array manager.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Frame layout, MSB to LSB: {ts, mask, id[N-1] .. id[0], polynomial}.
// The offset helpers take the instance widths as arguments, so one package
// serves every parametrisation of the manager and of the transport layer.
package receiver_array_pkg;

   localparam int DEF_ID_W   = 17;
   localparam int DEF_POLY_W = 17;
   localparam int DEF_TS_W   = 24;
   localparam int MAX_RECV   = 8;

   // Polynomial always occupies the bottom of the frame.
   localparam int POLY_LSB   = 0;

   function automatic int frame_w(input int nb_recv, input int id_w,
                                  input int poly_w, input int ts_w);
      return ts_w + nb_recv + nb_recv * id_w + poly_w;
   endfunction

   function automatic int id_lsb(input int i, input int id_w, input int poly_w);
      return poly_w + i * id_w;
   endfunction

   function automatic int mask_lsb(input int nb_recv, input int id_w, input int poly_w);
      return poly_w + nb_recv * id_w;
   endfunction

   function automatic int ts_lsb(input int nb_recv, input int id_w, input int poly_w);
      return mask_lsb(nb_recv, id_w, poly_w) + nb_recv;
   endfunction

   // Number of set bits in a hit mask; narrower masks are zero-extended by the caller.
   function automatic logic [3:0] popcount(input logic [MAX_RECV-1:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < MAX_RECV; i++) begin
         n = n + {3'b000, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/frame_fifo.sv
// Generic synchronous show-ahead FIFO (head visible on data_out, no read latency).
// Latency: push in cycle t -> visible on data_out in t+1 when empty.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
//
// Ports:
//   clk_96MHz, rst_n  clock, asynchronous active-low reset
//   clear             synchronous flush (pointers and level to zero), beats push/pop
//   push, data_in     write request and data
//   pop               read request; ignored while empty
//   data_out          head entry; holds the last-read entry while empty
//   level, full, empty occupancy status
module frame_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk_96MHz,
   input  logic                       rst_n,
   input  logic                       clear,
   input  logic                       push,
   input  logic [WIDTH-1:0]           data_in,
   input  logic                       pop,
   output logic [WIDTH-1:0]           data_out,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LW = $clog2(DEPTH + 1);
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
   localparam logic [LW-1:0] LVL_ONE  = LW'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [LW-1:0]    cnt;
   logic [WIDTH-1:0] last_q;
   logic             do_push;
   logic             do_pop;

   assign full     = (cnt == FULL_LVL);
   assign empty    = (cnt == '0);
   assign level    = cnt;
   assign do_pop   = pop & ~empty & ~clear;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_push  = push & (~full | do_pop) & ~clear;
   // last_q keeps data_out quiet (zero after reset) while nothing is queued.
   assign data_out = empty ? last_q : mem[rd_ptr];

   always_ff @(posedge clk_96MHz) begin
      if (do_push) begin
         mem[wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge clk_96MHz or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         last_q <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
            last_q <= mem[rd_ptr];
         end
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + LVL_ONE;
            2'b01:   cnt <= cnt - LVL_ONE;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/receiver_array_manager.sv
// Stamps per-receiver pulse-id sets with sys_ts and hit mask, filters on hit count, queues frames.
// Latency: id_valid in cycle t -> frame_valid/frame_data in t+2 (empty FIFO).
// Backpressure: frames queue in FIFO_DEPTH entries; a push into a full FIFO without a pop is dropped and counted.
//
// Ports:
//   clk_96MHz, rst_n            clock, asynchronous active-low reset
//   sys_ts                      free-running timestamp, sampled in the id_valid cycle
//   clear                       synchronous flush of capture stage, FIFO and counters
//   id_valid, id_mask,
//   pulse_ids, polynomial       one-cycle result set from the pulse identifier
//   frame_valid, frame_ready,
//   frame_data                  valid/ready frame output (FIFO head)
//   fifo_level                  occupied FIFO entries
//   overflow_cnt, reject_cnt    saturating drop counters (FIFO full / too few hits)
//   state_led                   toggles on every frame written into the FIFO
module receiver_array_manager
   import receiver_array_pkg::*;
#(
   parameter int NB_RECV    = 3,
   parameter int ID_W       = DEF_ID_W,
   parameter int POLY_W     = DEF_POLY_W,
   parameter int TS_W       = DEF_TS_W,
   parameter int FIFO_DEPTH = 4,
   parameter int MIN_HITS   = 1
) (
   input  logic                                           clk_96MHz,
   input  logic                                           rst_n,
   input  logic [TS_W-1:0]                                sys_ts,
   input  logic                                           clear,
   input  logic                                           id_valid,
   input  logic [NB_RECV-1:0]                             id_mask,
   input  logic [NB_RECV*ID_W-1:0]                        pulse_ids,
   input  logic [POLY_W-1:0]                              polynomial,
   output logic                                           frame_valid,
   input  logic                                           frame_ready,
   output logic [frame_w(NB_RECV, ID_W, POLY_W, TS_W)-1:0] frame_data,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]                fifo_level,
   output logic [7:0]                                     overflow_cnt,
   output logic [7:0]                                     reject_cnt,
   output logic                                           state_led
);

   localparam int FRAME_W  = frame_w(NB_RECV, ID_W, POLY_W, TS_W);
   localparam int MASK_LSB = mask_lsb(NB_RECV, ID_W, POLY_W);
   localparam logic [3:0] MIN_HITS_L = 4'(MIN_HITS);

   // ---------------- Stage 1: capture ----------------
   logic [NB_RECV*ID_W-1:0] masked_ids;
   logic                    cap_valid;
   logic [FRAME_W-1:0]      cap_frame;

   // Receivers that did not report contribute an all-zero id field.
   always_comb begin
      masked_ids = '0;
      for (int i = 0; i < NB_RECV; i++) begin
         if (id_mask[i]) begin
            masked_ids[i*ID_W +: ID_W] = pulse_ids[i*ID_W +: ID_W];
         end
      end
   end

   always_ff @(posedge clk_96MHz or negedge rst_n) begin
      if (!rst_n) begin
         cap_valid <= 1'b0;
         cap_frame <= '0;
      end else if (clear) begin
         cap_valid <= 1'b0;
      end else begin
         cap_valid <= id_valid;
         if (id_valid) begin
            cap_frame <= {sys_ts, id_mask, masked_ids, polynomial};
         end
      end
   end

   // ---------------- Stage 2: qualify / push ----------------
   logic [MAX_RECV-1:0] mask_ext;
   logic [3:0]          hits;
   logic                hit_ok;
   logic                push_req;
   logic                reject;
   logic                pop_eff;
   logic                drop;
   logic                written;
   logic                fifo_full;
   logic                fifo_empty;

   always_comb begin
      mask_ext = '0;
      mask_ext[NB_RECV-1:0] = cap_frame[MASK_LSB +: NB_RECV];
   end

   assign hits        = popcount(mask_ext);
   assign hit_ok      = (hits >= MIN_HITS_L);
   // clear wins over a pending frame: it is neither queued nor counted.
   assign push_req    = cap_valid & hit_ok & ~clear;
   assign reject      = cap_valid & ~hit_ok & ~clear;
   assign frame_valid = ~fifo_empty;
   assign pop_eff     = frame_valid & frame_ready;
   assign drop        = push_req & fifo_full & ~pop_eff;
   assign written     = push_req & ~drop;

   frame_fifo #(
      .WIDTH (FRAME_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_96MHz (clk_96MHz),
      .rst_n     (rst_n),
      .clear     (clear),
      .push      (push_req),
      .data_in   (cap_frame),
      .pop       (frame_ready),
      .data_out  (frame_data),
      .level     (fifo_level),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Counters saturate at 255; state_led survives clear so the LED does not glitch.
   always_ff @(posedge clk_96MHz or negedge rst_n) begin
      if (!rst_n) begin
         overflow_cnt <= '0;
         reject_cnt   <= '0;
         state_led    <= 1'b0;
      end else if (clear) begin
         overflow_cnt <= '0;
         reject_cnt   <= '0;
      end else begin
         if (drop && (overflow_cnt != 8'hFF)) begin
            overflow_cnt <= overflow_cnt + 8'd1;
         end
         if (reject && (reject_cnt != 8'hFF)) begin
            reject_cnt <= reject_cnt + 8'd1;
         end
         if (written) begin
            state_led <= ~state_led;
         end
      end
   end

endmodule

// File: tb/tb_receiver_array_manager.sv
module tb_receiver_array_manager;

   localparam int FW = 95;   // 24 + 3 + 3*17 + 17

   logic          clk_96MHz;
   logic          rst_n;
   logic [23:0]   sys_ts;
   logic          clear;
   logic          id_valid;
   logic [2:0]    id_mask;
   logic [50:0]   pulse_ids;
   logic [16:0]   polynomial;
   logic          frame_valid;
   logic          frame_ready;
   logic [FW-1:0] frame_data;
   logic [2:0]    fifo_level;
   logic [7:0]    overflow_cnt;
   logic [7:0]    reject_cnt;
   logic          state_led;

   int n_chk  = 0;
   int n_fail = 0;

   receiver_array_manager #(
      .NB_RECV    (3),
      .ID_W       (17),
      .POLY_W     (17),
      .TS_W       (24),
      .FIFO_DEPTH (4),
      .MIN_HITS   (2)
   ) dut (
      .clk_96MHz    (clk_96MHz),
      .rst_n        (rst_n),
      .sys_ts       (sys_ts),
      .clear        (clear),
      .id_valid     (id_valid),
      .id_mask      (id_mask),
      .pulse_ids    (pulse_ids),
      .polynomial   (polynomial),
      .frame_valid  (frame_valid),
      .frame_ready  (frame_ready),
      .frame_data   (frame_data),
      .fifo_level   (fifo_level),
      .overflow_cnt (overflow_cnt),
      .reject_cnt   (reject_cnt),
      .state_led    (state_led)
   );

   initial begin
      clk_96MHz = 1'b0;
      forever #5 clk_96MHz = ~clk_96MHz;
   end

   typedef struct {
      logic [23:0]   ts;
      logic [2:0]    mask;
      logic [50:0]   ids;
      logic [16:0]   poly;
      logic          acc;
      logic [FW-1:0] exp;
   } vec_t;

   vec_t tbl [7];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Inputs change 1 ns after the rising edge; outputs are sampled there too.
   task automatic tick();
      @(posedge clk_96MHz);
      #1;
      sys_ts = sys_ts + 24'd1;
   endtask

   task automatic drive(input logic [23:0] ts, input logic [2:0] m,
                        input logic [50:0] ids, input logic [16:0] p);
      sys_ts     = ts;
      id_mask    = m;
      pulse_ids  = ids;
      polynomial = p;
      id_valid   = 1'b1;
   endtask

   logic [FW-1:0] frames [6];
   logic [23:0]   ts_k;
   logic [50:0]   ids_k;
   logic [16:0]   poly_k;
   logic [7:0]    exp_ovf;
   logic [7:0]    exp_rej;
   logic          exp_led;

   initial begin
      tbl[0] = '{ts:24'h000100, mask:3'b111, ids:{17'h00003, 17'h00002, 17'h00001}, poly:17'h0ABCD,
                 acc:1'b1, exp:{24'h000100, 3'b111, 17'h00003, 17'h00002, 17'h00001, 17'h0ABCD}};
      tbl[1] = '{ts:24'h000200, mask:3'b010, ids:{17'h00007, 17'h00005, 17'h1FFFF}, poly:17'h00055,
                 acc:1'b0, exp:'0};
      tbl[2] = '{ts:24'h000300, mask:3'b011, ids:{17'h1AAAA, 17'h00123, 17'h1FFFF}, poly:17'h1F0F0,
                 acc:1'b1, exp:{24'h000300, 3'b011, 17'h00000, 17'h00123, 17'h1FFFF, 17'h1F0F0}};
      tbl[3] = '{ts:24'hABCDEF, mask:3'b101, ids:{17'h00F00, 17'h15555, 17'h0AAAA}, poly:17'h00001,
                 acc:1'b1, exp:{24'hABCDEF, 3'b101, 17'h00F00, 17'h00000, 17'h0AAAA, 17'h00001}};
      tbl[4] = '{ts:24'h000400, mask:3'b000, ids:{17'h00001, 17'h00002, 17'h00003}, poly:17'h00000,
                 acc:1'b0, exp:'0};
      tbl[5] = '{ts:24'hFFFFFF, mask:3'b110, ids:{17'h10000, 17'h1FFFF, 17'h12345}, poly:17'h1FFFF,
                 acc:1'b1, exp:{24'hFFFFFF, 3'b110, 17'h10000, 17'h1FFFF, 17'h00000, 17'h1FFFF}};
      tbl[6] = '{ts:24'h000500, mask:3'b100, ids:{17'h1FFFF, 17'h00000, 17'h00000}, poly:17'h00001,
                 acc:1'b0, exp:'0};

      rst_n = 1'b0; sys_ts = '0; clear = 1'b0; id_valid = 1'b0; id_mask = '0;
      pulse_ids = '0; polynomial = '0; frame_ready = 1'b0;
      exp_ovf = '0; exp_rej = '0; exp_led = 1'b0;

      // ---------------- Reset state ----------------
      tick(); tick();
      chk("rst_valid", frame_valid, 1'b0);
      chk("rst_data", frame_data, '0);
      chk("rst_level", fifo_level, 3'd0);
      chk("rst_ovf", overflow_cnt, 8'd0);
      chk("rst_rej", reject_cnt, 8'd0);
      chk("rst_led", state_led, 1'b0);
      rst_n = 1'b1;
      tick();

      // ---------------- Table: single frames, latency and hit filter ----------------
      frame_ready = 1'b1;
      for (int v = 0; v < 7; v++) begin
         drive(tbl[v].ts, tbl[v].mask, tbl[v].ids, tbl[v].poly);
         tick();
         id_valid = 1'b0;
         chk("tbl_t1_valid", frame_valid, 1'b0);
         tick();
         if (tbl[v].acc) begin
            exp_led = ~exp_led;
            chk("tbl_t2_valid", frame_valid, 1'b1);
            chk("tbl_t2_data", frame_data, tbl[v].exp);
            chk("tbl_t2_level", fifo_level, 3'd1);
         end else begin
            exp_rej = exp_rej + 8'd1;
            chk("tbl_rej_valid", frame_valid, 1'b0);
            chk("tbl_rej_level", fifo_level, 3'd0);
         end
         chk("tbl_rej_cnt", reject_cnt, exp_rej);
         chk("tbl_led", state_led, exp_led);
         tick();
         chk("tbl_t3_level", fifo_level, 3'd0);
         chk("tbl_t3_valid", frame_valid, 1'b0);
      end

      // ---------------- Six back-to-back frames into a stalled FIFO ----------------
      frame_ready = 1'b0;
      for (int k = 0; k < 6; k++) begin
         ts_k   = 24'h010000 + 24'(k);
         ids_k  = {17'(k + 20), 17'(k + 10), 17'(k)};
         poly_k = 17'h00100 + 17'(k);
         frames[k] = {ts_k, 3'b111, ids_k, poly_k};
         drive(ts_k, 3'b111, ids_k, poly_k);
         tick();
      end
      id_valid = 1'b0;
      tick();
      exp_ovf = 8'd2;
      exp_led = ~exp_led; exp_led = ~exp_led; exp_led = ~exp_led; exp_led = ~exp_led;
      chk("b2b_level", fifo_level, 3'd4);
      chk("b2b_ovf", overflow_cnt, exp_ovf);
      chk("b2b_head", frame_data, frames[0]);
      chk("b2b_led", state_led, exp_led);
      tick();
      chk("b2b_hold_valid", frame_valid, 1'b1);
      chk("b2b_hold_data", frame_data, frames[0]);
      frame_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk("b2b_drain_valid", frame_valid, 1'b1);
         chk("b2b_drain_data", frame_data, frames[k]);
         tick();
      end
      chk("b2b_empty_valid", frame_valid, 1'b0);
      chk("b2b_empty_level", fifo_level, 3'd0);

      // ---------------- Push coincident with pop at full ----------------
      frame_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         ts_k   = 24'h020000 + 24'(k);
         ids_k  = {17'(k + 7), 17'(k + 5), 17'(k + 3)};
         poly_k = 17'h00200 + 17'(k);
         frames[k] = {ts_k, 3'b111, ids_k, poly_k};
         drive(ts_k, 3'b111, ids_k, poly_k);
         tick();
      end
      id_valid = 1'b0;
      chk("pp_full_level", fifo_level, 3'd4);
      frame_ready = 1'b1;
      tick();
      frame_ready = 1'b0;
      exp_led = ~exp_led; exp_led = ~exp_led; exp_led = ~exp_led; exp_led = ~exp_led; exp_led = ~exp_led;
      chk("pp_level", fifo_level, 3'd4);
      chk("pp_ovf", overflow_cnt, exp_ovf);
      chk("pp_head", frame_data, frames[1]);
      chk("pp_led", state_led, exp_led);
      frame_ready = 1'b1;
      for (int k = 1; k < 5; k++) begin
         chk("pp_drain_data", frame_data, frames[k]);
         tick();
      end
      chk("pp_empty_valid", frame_valid, 1'b0);

      // ---------------- Overflow saturation and clear ----------------
      frame_ready = 1'b0;
      for (int n = 0; n < 310; n++) begin
         drive(24'h030000 + 24'(n), 3'b111, {17'(n), 17'(n), 17'(n)}, 17'(n));
         tick();
      end
      exp_led = ~exp_led; exp_led = ~exp_led; exp_led = ~exp_led; exp_led = ~exp_led;
      chk("sat_ovf", overflow_cnt, 8'd255);
      chk("sat_level", fifo_level, 3'd4);
      id_valid = 1'b0;
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("clr_level", fifo_level, 3'd0);
      chk("clr_valid", frame_valid, 1'b0);
      chk("clr_ovf", overflow_cnt, 8'd0);
      chk("clr_rej", reject_cnt, 8'd0);
      chk("clr_led", state_led, exp_led);
      tick();
      chk("clr_pending_lost", fifo_level, 3'd0);
      drive(24'h040000, 3'b111, {17'h1, 17'h2, 17'h3}, 17'h4);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      id_valid = 1'b0;
      tick(); tick();
      chk("clr_id_valid", frame_valid, 1'b0);
      chk("clr_id_level", fifo_level, 3'd0);
      chk("clr_id_led", state_led, exp_led);
      frame_ready = 1'b1;
      drive(24'h050000, 3'b011, {17'h1, 17'h2, 17'h3}, 17'h4);
      tick();
      id_valid = 1'b0;
      tick();
      exp_led = ~exp_led;
      chk("post_clr_valid", frame_valid, 1'b1);
      chk("post_clr_data", frame_data, {24'h050000, 3'b011, 17'h0, 17'h2, 17'h3, 17'h4});
      tick();

      // ---------------- Asynchronous reset mid-stream ----------------
      drive(24'h060000, 3'b001, {17'h1, 17'h2, 17'h3}, 17'h4);
      tick();
      id_valid = 1'b0;
      tick();
      chk("pre_rst_rej", reject_cnt, 8'd1);
      frame_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         drive(24'h070000 + 24'(k), 3'b111, {17'(k), 17'(k), 17'(k)}, 17'(k));
         tick();
      end
      id_valid = 1'b0;
      exp_led = ~exp_led; exp_led = ~exp_led; exp_led = ~exp_led;
      chk("pre_rst_level", fifo_level, 3'd3);
      chk("pre_rst_led", state_led, exp_led);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", frame_valid, 1'b0);
      chk("arst_data", frame_data, '0);
      chk("arst_level", fifo_level, 3'd0);
      chk("arst_rej", reject_cnt, 8'd0);
      chk("arst_led", state_led, 1'b0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("arst_no_survivor", fifo_level, 3'd0);
      frame_ready = 1'b1;
      drive(24'h123456, 3'b111, {17'h0AAAA, 17'h15555, 17'h00042}, 17'h0F00F);
      tick();
      id_valid = 1'b0;
      chk("arst_t1_valid", frame_valid, 1'b0);
      tick();
      chk("arst_t2_valid", frame_valid, 1'b1);
      chk("arst_t2_data", frame_data, {24'h123456, 3'b111, 17'h0AAAA, 17'h15555, 17'h00042, 17'h0F00F});
      chk("arst_t2_level", fifo_level, 3'd1);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
